// File: rtl/demux_pkg.sv
// Shared definitions for the 1:2 stream demultiplexer.
//   BUF_DEPTH  : entries per output elastic buffer
//   buf_cnt_t  : fill count type (0..BUF_DEPTH)
//   dest_e     : decoded destination of an input item
//   PERF_CNT_W : width of the optional handshake counters (DEMUX_PERF_CNT_EN)
package demux_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] buf_cnt_t;

  typedef enum logic {
    DEST_OUT0 = 1'b0,
    DEST_OUT1 = 1'b1
  } dest_e;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready elastic buffer.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push, push_data   : write request and payload (ignored while full)
//   full              : registered full flag, used by the producer as ready
//   valid, ready, data: consumer side; data is the head entry
// The producer-facing full flag is derived only from the registered count,
// so there is no combinational path from ready to the upstream ready.
module stream_buf2
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  buf_cnt_t         count;
  logic             push_ok;
  logic             pop;

  assign full    = (count == buf_cnt_t'(BUF_DEPTH));
  assign valid   = (count != '0);
  assign data    = mem[rd_ptr];
  // A push into a full buffer is dropped even if a pop happens this cycle.
  assign push_ok = push & ~full;
  assign pop     = valid & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to2.sv
// 1:2 stream demultiplexer: steers one valid/ready stream to out0 or out1
// according to in_sel, each output behind a 2-entry elastic buffer
// (1-cycle latency, full throughput, in_ready independent of out*_ready).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_sel: input stream and destination select
//   out0_valid/out0_ready/out0_data : channel 0 stream
//   out1_valid/out1_ready/out1_data : channel 1 stream
//   out0_count/out1_count           : completed output handshakes, wrapping
//                                     (only when DEMUX_PERF_CNT_EN is defined)
module demux_1to2
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_sel,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [WIDTH-1:0]      out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [WIDTH-1:0]      out1_data
`ifdef DEMUX_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] out0_count,
  output logic [PERF_CNT_W-1:0] out1_count
`endif
);

  dest_e dest;
  logic  full0;
  logic  full1;
  logic  push0;
  logic  push1;

  assign dest     = dest_e'(in_sel);
  // Only the selected channel's fill state matters; the other may be full.
  assign in_ready = (dest == DEST_OUT1) ? ~full1 : ~full0;
  assign push0    = in_valid & in_ready & (dest == DEST_OUT0);
  assign push1    = in_valid & in_ready & (dest == DEST_OUT1);

  stream_buf2 #(.WIDTH(WIDTH)) u_buf0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .valid     (out0_valid),
    .ready     (out0_ready),
    .data      (out0_data)
  );

  stream_buf2 #(.WIDTH(WIDTH)) u_buf1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .valid     (out1_valid),
    .ready     (out1_ready),
    .data      (out1_data)
  );

`ifdef DEMUX_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] cnt0;
  logic [PERF_CNT_W-1:0] cnt1;

  // Free-running handshake counters; wrap naturally at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (out0_valid & out0_ready) cnt0 <= cnt0 + 1'b1;
      if (out1_valid & out1_ready) cnt1 <= cnt1 + 1'b1;
    end
  end

  assign out0_count = cnt0;
  assign out1_count = cnt1;
`endif

endmodule

// File: tb/tb_demux_1to2.sv
// Self-checking bench for demux_1to2: directed steps followed by random
// traffic, all compared against a queue-based model of the two channels.
module tb_demux_1to2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
`ifdef DEMUX_PERF_CNT_EN
  logic [31:0] out0_count;
  logic [31:0] out1_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] n0 = 0;
  logic [31:0] n1 = 0;

  demux_1to2 #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_PERF_CNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then apply
  // the handshakes the model predicts at the rising edge.
  task automatic step();
    bit acc, p0, p1;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready},
        {31'b0, (in_sel ? q1.size() : q0.size()) < 2});
    chk("out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() != 0});
    chk("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
    if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
`ifdef DEMUX_PERF_CNT_EN
    chk("out0_count", out0_count, n0);
    chk("out1_count", out1_count, n1);
`endif
    acc = in_valid && ((in_sel ? q1.size() : q0.size()) < 2);
    p0  = (q0.size() != 0) && out0_ready;
    p1  = (q1.size() != 0) && out1_ready;
    @(posedge clk);
    if (p0) begin void'(q0.pop_front()); n0++; end
    if (p1) begin void'(q1.pop_front()); n1++; end
    if (acc) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("rst_out0_valid", {31'b0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("rst_out0_data", out0_data, 32'd0);
    chk("rst_out1_data", out1_data, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // First item to out0, visible one cycle after acceptance.
    drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("first_out0_valid", {31'b0, out0_valid}, 32'd1);
    chk("first_out0_data", out0_data, 32'hDEADBEEF);
    chk("first_out1_valid", {31'b0, out1_valid}, 32'd0);
    step();
    step();

    // Alternating stream with both consumers ready.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, ((i - 1) % 2) == 1, 32'(i), 1'b1, 1'b1);
      chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    step();

    // Backpressure on out0 does not block out1.
    drive(1'b1, 1'b0, 32'hA, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 32'hB, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 32'hD, 1'b0, 1'b1);
    #1;
    chk("bp_blocked", {31'b0, in_ready}, 32'd0);
    in_sel  = 1'b1;
    in_data = 32'hC;
    #1;
    chk("bp_other_ok", {31'b0, in_ready}, 32'd1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_out1_data", out1_data, 32'hC);
    step();

    // Full with pop: registered ready stays low that cycle.
    drive(1'b1, 1'b0, 32'hE, 1'b1, 1'b0);
    chk("full_pop_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("full_pop_ready_next", {31'b0, in_ready}, 32'd1);
    chk("full_pop_head", out0_data, 32'hB);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step();

    // Reset mid-operation with both buffers full.
    drive(1'b1, 1'b0, 32'h11, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 32'h22, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 32'h33, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out0_valid", {31'b0, out0_valid}, 32'd0);
    chk("mid_rst_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("mid_rst_out0_data", out0_data, 32'd0);
    chk("mid_rst_out1_data", out1_data, 32'd0);
    q0.delete();
    q1.delete();
    n0 = 0;
    n1 = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step();
    in_sel = 1'b1;
    step();

`ifdef DEMUX_PERF_CNT_EN
    // 5 pops on out0, 3 on out1.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(100 + i), 1'b1, 1'b1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'(200 + i), 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    step();
    chk("perf_out0_5", out0_count, 32'd5);
    chk("perf_out1_3", out1_count, 32'd3);
    force dut.cnt0 = 32'hFFFFFFFF;
    #1;
    release dut.cnt0;
    n0 = 32'hFFFFFFFF;
    drive(1'b1, 1'b0, 32'h55, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    chk("perf_wrap", out0_count, 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
